// File: rtl/gfx_triangle_scheduler.sv
// gfx_triangle_scheduler
//   Queues triangle draw commands from the register front-end in a small
//   circular FIFO and feeds them one at a time to the triangle rasterizer.
//   While a triangle is being rasterized, its vertices are held stable on
//   tri_p*_o. On the rasterizer's ack, the triangle is retired and counted
//   as drawn (area > 0) or culled (area <= 0).
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   cmd_write_i, cmd_p*_i     push one triangle command (six signed coords)
//   cmd_full_o                FIFO is full
//   flush_i                   drop every queued command that has not been launched
//   tri_write_o, tri_p*_o     one-cycle launch strobe and held vertices to rasterizer
//   tri_ack_i, tri_area_i     rasterizer done ack and signed area of the triangle
//   busy_o, count_o           activity flag and FIFO occupancy
//   overflow_o                sticky flag: a push arrived while the FIFO was full
//   drawn_cnt_o, culled_cnt_o retirement statistics, wrap on overflow
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing in flight; launch the head when the FIFO is non-empty
// LAUNCH | tri_write_o high for this single cycle
// WAIT   | triangle in flight; retire and pop it on tri_ack_i
module gfx_triangle_scheduler #(
    parameter int point_width     = 16,
    parameter int subpixel_width  = 16,
    parameter int fifo_depth_log2 = 2,
    parameter int cnt_width       = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              cmd_write_i,
    input  logic [point_width+subpixel_width-1:0] cmd_p0x_i,
    input  logic [point_width+subpixel_width-1:0] cmd_p0y_i,
    input  logic [point_width+subpixel_width-1:0] cmd_p1x_i,
    input  logic [point_width+subpixel_width-1:0] cmd_p1y_i,
    input  logic [point_width+subpixel_width-1:0] cmd_p2x_i,
    input  logic [point_width+subpixel_width-1:0] cmd_p2y_i,
    output logic                              cmd_full_o,
    input  logic                              flush_i,
    output logic                              tri_write_o,
    output logic [point_width+subpixel_width-1:0] tri_p0x_o,
    output logic [point_width+subpixel_width-1:0] tri_p0y_o,
    output logic [point_width+subpixel_width-1:0] tri_p1x_o,
    output logic [point_width+subpixel_width-1:0] tri_p1y_o,
    output logic [point_width+subpixel_width-1:0] tri_p2x_o,
    output logic [point_width+subpixel_width-1:0] tri_p2y_o,
    input  logic                              tri_ack_i,
    input  logic [2*point_width-1:0]          tri_area_i,
    output logic                              busy_o,
    output logic [fifo_depth_log2:0]          count_o,
    output logic                              overflow_o,
    output logic [cnt_width-1:0]              drawn_cnt_o,
    output logic [cnt_width-1:0]              culled_cnt_o
);

    localparam int W     = point_width + subpixel_width;
    localparam int D     = fifo_depth_log2;
    localparam int DEPTH = 1 << D;
    localparam logic [D:0] FULL_CNT = (D+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t           state;
    logic [6*W-1:0]   mem [DEPTH];
    logic [D-1:0]     wr_ptr;
    logic [D-1:0]     rd_ptr;
    logic [D:0]       count;
    logic [6*W-1:0]   head;
    logic             push_ok;
    logic             pop;

    // Full is judged on the current occupancy, so a push that coincides
    // with a pop while full is still dropped. Flush overrides any push.
    assign cmd_full_o = (count == FULL_CNT);
    assign push_ok    = cmd_write_i && !cmd_full_o && !flush_i;
    assign pop        = (state == WAIT) && tri_ack_i;
    assign head       = mem[rd_ptr];
    assign count_o    = count;
    assign busy_o     = (count != '0) || (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= {cmd_p0x_i, cmd_p0y_i, cmd_p1x_i,
                            cmd_p1y_i, cmd_p2x_i, cmd_p2y_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tri_write_o  <= 1'b0;
            overflow_o   <= 1'b0;
            drawn_cnt_o  <= '0;
            culled_cnt_o <= '0;
            tri_p0x_o    <= '0;
            tri_p0y_o    <= '0;
            tri_p1x_o    <= '0;
            tri_p1y_o    <= '0;
            tri_p2x_o    <= '0;
            tri_p2y_o    <= '0;
        end else begin
            tri_write_o <= 1'b0;

            if (cmd_write_i && cmd_full_o && !flush_i) begin
                overflow_o <= 1'b1;
            end

            if (flush_i) begin
                if (state == IDLE) begin
                    wr_ptr <= rd_ptr;
                    count  <= '0;
                end else if (pop) begin
                    // in-flight head retires this same cycle: queue ends empty
                    rd_ptr <= rd_ptr + D'(1);
                    wr_ptr <= rd_ptr + D'(1);
                    count  <= '0;
                end else begin
                    // keep only the in-flight head
                    wr_ptr <= rd_ptr + D'(1);
                    count  <= (D+1)'(1);
                end
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + D'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + D'(1);
                end
                count <= count + (D+1)'(push_ok) - (D+1)'(pop);
            end

            case (state)
                IDLE: begin
                    if (count != '0 && !flush_i) begin
                        state       <= LAUNCH;
                        tri_write_o <= 1'b1;
                        {tri_p0x_o, tri_p0y_o, tri_p1x_o,
                         tri_p1y_o, tri_p2x_o, tri_p2y_o} <= head;
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (tri_ack_i) begin
                        if ($signed(tri_area_i) > 0) begin
                            drawn_cnt_o <= drawn_cnt_o + cnt_width'(1);
                        end else begin
                            culled_cnt_o <= culled_cnt_o + cnt_width'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_triangle_scheduler.sv
module tb_gfx_triangle_scheduler;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_write_i;
    logic [W-1:0]  cmd_p0x_i, cmd_p0y_i, cmd_p1x_i, cmd_p1y_i, cmd_p2x_i, cmd_p2y_i;
    logic          cmd_full_o;
    logic          flush_i;
    logic          tri_write_o;
    logic [W-1:0]  tri_p0x_o, tri_p0y_o, tri_p1x_o, tri_p1y_o, tri_p2x_o, tri_p2y_o;
    logic          tri_ack_i;
    logic [31:0]   tri_area_i;
    logic          busy_o;
    logic [2:0]    count_o;
    logic          overflow_o;
    logic [15:0]   drawn_cnt_o;
    logic [15:0]   culled_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] launch_log [$];

    gfx_triangle_scheduler dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_write_i  (cmd_write_i),
        .cmd_p0x_i    (cmd_p0x_i),
        .cmd_p0y_i    (cmd_p0y_i),
        .cmd_p1x_i    (cmd_p1x_i),
        .cmd_p1y_i    (cmd_p1y_i),
        .cmd_p2x_i    (cmd_p2x_i),
        .cmd_p2y_i    (cmd_p2y_i),
        .cmd_full_o   (cmd_full_o),
        .flush_i      (flush_i),
        .tri_write_o  (tri_write_o),
        .tri_p0x_o    (tri_p0x_o),
        .tri_p0y_o    (tri_p0y_o),
        .tri_p1x_o    (tri_p1x_o),
        .tri_p1y_o    (tri_p1y_o),
        .tri_p2x_o    (tri_p2x_o),
        .tri_p2y_o    (tri_p2y_o),
        .tri_ack_i    (tri_ack_i),
        .tri_area_i   (tri_area_i),
        .busy_o       (busy_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .drawn_cnt_o  (drawn_cnt_o),
        .culled_cnt_o (culled_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // every launch strobe seen, keyed by the p0x coordinate presented with it
    always @(negedge clk_i) begin
        if (tri_write_o) launch_log.push_back(tri_p0x_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] p0x, input logic [W-1:0] p0y,
                        input logic [W-1:0] p1x, input logic [W-1:0] p1y,
                        input logic [W-1:0] p2x, input logic [W-1:0] p2y);
        cmd_write_i = 1'b1;
        cmd_p0x_i = p0x; cmd_p0y_i = p0y; cmd_p1x_i = p1x;
        cmd_p1y_i = p1y; cmd_p2x_i = p2x; cmd_p2y_i = p2y;
        tick();
        cmd_write_i = 1'b0;
    endtask

    // ack in the current cycle, then wait until a following launch (if any) is in WAIT
    task automatic ack(input logic [31:0] area);
        tri_ack_i  = 1'b1;
        tri_area_i = area;
        tick();
        tri_ack_i  = 1'b0;
        tri_area_i = '0;
        tick();
        tick();
    endtask

    initial begin
        rst_i = 1'b1; cmd_write_i = 1'b0; flush_i = 1'b0;
        tri_ack_i = 1'b0; tri_area_i = '0;
        cmd_p0x_i = '0; cmd_p0y_i = '0; cmd_p1x_i = '0;
        cmd_p1y_i = '0; cmd_p2x_i = '0; cmd_p2y_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_write", 64'(tri_write_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_full", 64'(cmd_full_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_drawn", 64'(drawn_cnt_o), 64'd0);
        chk("rst_culled", 64'(culled_cnt_o), 64'd0);
        chk("rst_p1x", 64'(tri_p1x_o), 64'd0);

        // 1: single triangle, launch latency and vertices
        push(32'd0, 32'd0, 32'h000A_0000, 32'd0, 32'd0, 32'h000A_0000);
        chk("t1_c1_write", 64'(tri_write_o), 64'd0);
        chk("t1_c1_count", 64'(count_o), 64'd1);
        tick();
        chk("t1_c2_write", 64'(tri_write_o), 64'd1);
        chk("t1_p0x", 64'(tri_p0x_o), 64'd0);
        chk("t1_p1x", 64'(tri_p1x_o), 64'h000A_0000);
        chk("t1_p1y", 64'(tri_p1y_o), 64'd0);
        chk("t1_p2y", 64'(tri_p2y_o), 64'h000A_0000);
        tick();
        chk("t1_c3_write", 64'(tri_write_o), 64'd0);
        chk("t1_c3_hold", 64'(tri_p2y_o), 64'h000A_0000);
        tri_ack_i = 1'b1; tri_area_i = 32'd100;
        tick();
        tri_ack_i = 1'b0; tri_area_i = '0;
        chk("t1_drawn", 64'(drawn_cnt_o), 64'd1);
        chk("t1_count", 64'(count_o), 64'd0);
        tick();
        chk("t1_busy", 64'(busy_o), 64'd0);
        chk("t1_launches", 64'(launch_log.size()), 64'd1);

        // 2: five pushes with no ack, fourth fills, fifth overflows
        push(32'd1, 32'd11, 32'd21, 32'd31, 32'd41, 32'd51);
        push(32'd2, 32'd12, 32'd22, 32'd32, 32'd42, 32'd52);
        push(32'd3, 32'd13, 32'd23, 32'd33, 32'd43, 32'd53);
        chk("t2_not_full", 64'(cmd_full_o), 64'd0);
        push(32'd4, 32'd14, 32'd24, 32'd34, 32'd44, 32'd54);
        chk("t2_full", 64'(cmd_full_o), 64'd1);
        chk("t2_ovf_before", 64'(overflow_o), 64'd0);
        push(32'd5, 32'd15, 32'd25, 32'd35, 32'd45, 32'd55);
        chk("t2_ovf", 64'(overflow_o), 64'd1);
        chk("t2_count", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) ack(32'd1);
        chk("t2_launches", 64'(launch_log.size()), 64'd5);
        for (int i = 1; i < 5 && i < launch_log.size(); i++)
            chk("t2_order", 64'(launch_log[i]), 64'(i));
        chk("t2_drawn", 64'(drawn_cnt_o), 64'd5);
        chk("t2_count_end", 64'(count_o), 64'd0);
        chk("t2_ovf_sticky", 64'(overflow_o), 64'd1);

        // 3: zero and negative area are culled
        push(32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        push(32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        ack(32'd0);
        ack(-32'sd50);
        chk("t3_culled", 64'(culled_cnt_o), 64'd2);
        chk("t3_drawn", 64'(drawn_cnt_o), 64'd5);
        chk("t3_launches", 64'(launch_log.size()), 64'd7);

        // 4: flush while the head is in flight
        push(32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        push(32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        push(32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("t4_count3", 64'(count_o), 64'd3);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t4_count1", 64'(count_o), 64'd1);
        ack(32'd7);
        tick(); tick(); tick();
        chk("t4_drawn", 64'(drawn_cnt_o), 64'd6);
        chk("t4_count0", 64'(count_o), 64'd0);
        chk("t4_busy", 64'(busy_o), 64'd0);
        chk("t4_launches", 64'(launch_log.size()), 64'd8);

        // 5: stale acks in IDLE and in LAUNCH
        tri_ack_i = 1'b1; tri_area_i = 32'd5;
        tick();
        tri_ack_i = 1'b0;
        chk("t5_idle_drawn", 64'(drawn_cnt_o), 64'd6);
        chk("t5_idle_culled", 64'(culled_cnt_o), 64'd2);
        push(32'd11, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("t5_in_launch", 64'(tri_write_o), 64'd1);
        tri_ack_i = 1'b1; tri_area_i = 32'd5;
        tick();
        tri_ack_i = 1'b0;
        chk("t5_launch_drawn", 64'(drawn_cnt_o), 64'd6);
        chk("t5_launch_count", 64'(count_o), 64'd1);
        ack(32'd5);
        chk("t5_real_drawn", 64'(drawn_cnt_o), 64'd7);
        chk("t5_real_count", 64'(count_o), 64'd0);

        // 6: reset in WAIT with two queued
        push(32'd12, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        push(32'd13, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("t6_count2", 64'(count_o), 64'd2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_drawn", 64'(drawn_cnt_o), 64'd0);
        chk("t6_culled", 64'(culled_cnt_o), 64'd0);
        chk("t6_ovf", 64'(overflow_o), 64'd0);
        chk("t6_p0x", 64'(tri_p0x_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        tick(); tick(); tick();
        chk("t6_launches", 64'(launch_log.size()), 64'd10);

        // flush and push together: push is dropped and not an overflow
        flush_i = 1'b1;
        push(32'd14, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        flush_i = 1'b0;
        chk("fp_count", 64'(count_o), 64'd0);
        chk("fp_ovf", 64'(overflow_o), 64'd0);
        tick(); tick();
        chk("fp_launches", 64'(launch_log.size()), 64'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
